seg_scan_capture: RTL and testbench

Captures the multiplexed, active-low seven-segment drive of the scanned 4-digit display and converts it back to hexadecimal digit values. It sits beside the display driver as an observer for self-check and debug: it waits for each digit's segment pattern to be stable for a set number of cycles, decodes it, and reports one complete multi-digit value per scan frame.

---
 rtl/seg_scan_capture.sv | 145 ++++++++++++++
 tb/tb_seg_scan_capture.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_capture.sv
// Observer for a scanned, active-low seven-segment display: qualifies each digit's
// dwell, decodes the pattern back to hex and publishes one value per full scan frame.
module seg_scan_capture #(
  parameter int NDIG          = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          seg,
  input  logic [NDIG-1:0]     an,
  output logic [4*NDIG-1:0]   value,
  output logic [NDIG-1:0]     dp,
  output logic                frame_valid,
  output logic                frame_err
);

  localparam int PW = NDIG + 8;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] RUN_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] RUN_PRE = CW'(STABLE_CYCLES - 1);

  // Returns {valid, nibble}; dp bit is not part of the pattern.
  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    case (s)
      7'b1000000: decode_seg = {1'b1, 4'h0};
      7'b1111001: decode_seg = {1'b1, 4'h1};
      7'b0100100: decode_seg = {1'b1, 4'h2};
      7'b0110000: decode_seg = {1'b1, 4'h3};
      7'b0011001: decode_seg = {1'b1, 4'h4};
      7'b0010010: decode_seg = {1'b1, 4'h5};
      7'b0000010: decode_seg = {1'b1, 4'h6};
      7'b1111000: decode_seg = {1'b1, 4'h7};
      7'b0000000: decode_seg = {1'b1, 4'h8};
      7'b0010000: decode_seg = {1'b1, 4'h9};
      7'b0001000: decode_seg = {1'b1, 4'hA};
      7'b0000011: decode_seg = {1'b1, 4'hB};
      7'b1000110: decode_seg = {1'b1, 4'hC};
      7'b0100001: decode_seg = {1'b1, 4'hD};
      7'b0000110: decode_seg = {1'b1, 4'hE};
      7'b0001110: decode_seg = {1'b1, 4'hF};
      default:    decode_seg = 5'b0_0000;
    endcase
  endfunction

  logic [PW-1:0]     cur_q, cur_d, prev_q, prev_d;
  logic [CW-1:0]     run_q, run_d;
  logic [NDIG-1:0]   seen_q, seen_d;
  logic              err_acc_q, err_acc_d;
  logic [4*NDIG-1:0] slot_q, slot_d;
  logic [NDIG-1:0]   slot_dp_q, slot_dp_d;
  logic [4*NDIG-1:0] value_q, value_d;
  logic [NDIG-1:0]   dp_q, dp_d;
  logic              frame_valid_q, frame_valid_d;
  logic              frame_err_q, frame_err_d;

  logic [NDIG-1:0]   cur_an, sel, seen_next;
  logic [7:0]        cur_seg;
  logic              qualified, same, accept, code_ok;
  logic [4:0]        code;

  always_comb begin
    cur_d     = {an, seg};
    prev_d    = cur_q;
    cur_an    = cur_q[PW-1:8];
    cur_seg   = cur_q[7:0];
    sel       = ~cur_an;
    qualified = $onehot(sel);
    same      = (cur_q == prev_q);

    if (qualified && same) begin
      run_d = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
    end else if (qualified) begin
      run_d = CW'(1);
    end else begin
      run_d = '0;
    end

    // Fires on the one cycle the run counter is about to reach its limit.
    accept  = qualified && same && (run_q == RUN_PRE);
    code    = decode_seg(cur_seg[6:0]);
    code_ok = code[4];

    slot_d    = slot_q;
    slot_dp_d = slot_dp_q;
    if (accept && code_ok) begin
      for (int i = 0; i < NDIG; i++) begin
        if (sel[i]) begin
          slot_d[4*i +: 4] = code[3:0];
          slot_dp_d[i]     = ~cur_seg[7];
        end
      end
    end

    seen_next     = seen_q | (accept ? sel : '0);
    seen_d        = seen_next;
    err_acc_d     = err_acc_q | (accept && !code_ok);
    value_d       = value_q;
    dp_d          = dp_q;
    frame_err_d   = frame_err_q;
    frame_valid_d = 1'b0;

    if (accept && (&seen_next)) begin
      value_d       = slot_d;
      dp_d          = slot_dp_d;
      frame_err_d   = err_acc_d;
      frame_valid_d = 1'b1;
      seen_d        = '0;
      err_acc_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q         <= '0;
      prev_q        <= '0;
      run_q         <= '0;
      seen_q        <= '0;
      err_acc_q     <= 1'b0;
      slot_q        <= '0;
      slot_dp_q     <= '0;
      value_q       <= '0;
      dp_q          <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      cur_q         <= cur_d;
      prev_q        <= prev_d;
      run_q         <= run_d;
      seen_q        <= seen_d;
      err_acc_q     <= err_acc_d;
      slot_q        <= slot_d;
      slot_dp_q     <= slot_dp_d;
      value_q       <= value_d;
      dp_q          <= dp_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign value       = value_q;
  assign dp          = dp_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Randomized bench for seg_scan_capture: a dwell-level reference model predicts
// each frame's edge and contents; every output is compared on the falling edge.
module tb_seg_scan_capture;

  localparam int NDIG = 4;
  localparam int S    = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [7:0]          seg;
  logic [NDIG-1:0]     an;
  logic [4*NDIG-1:0]   value;
  logic [NDIG-1:0]     dp;
  logic                frame_valid, frame_err;

  seg_scan_capture #(.NDIG(NDIG), .STABLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .an(an),
    .value(value), .dp(dp), .frame_valid(frame_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, got, exp);
    end
  endtask

  logic [6:0] tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  typedef struct {
    int                at_edge;
    logic [4*NDIG-1:0] val;
    logic [NDIG-1:0]   dpm;
    logic              err;
  } ev_t;
  ev_t exp_q[$];

  // Reference model state: frame in progress plus the current dwell.
  logic [4*NDIG-1:0] m_val;
  logic [NDIG-1:0]   m_dpm, m_seen;
  logic              m_err;
  logic [NDIG+7:0]   r_pins;
  int                r_start, r_len;
  bit                r_acc, r_fresh;

  task automatic m_clear();
    exp_q.delete();
    m_val = '0; m_dpm = '0; m_seen = '0; m_err = 1'b0;
    r_fresh = 1'b1; r_acc = 1'b0; r_len = 0; r_start = 0; r_pins = '0;
  endtask

  task automatic m_accept(input logic [NDIG-1:0] a, input logic [7:0] s, input int at);
    bit ok = 1'b0;
    logic [3:0] hv = '0;
    ev_t e;
    for (int h = 0; h < 16; h++)
      if (tab[h] == s[6:0]) begin ok = 1'b1; hv = 4'(h); end
    for (int i = 0; i < NDIG; i++) begin
      if (!a[i]) begin
        m_seen[i] = 1'b1;
        if (ok) begin m_val[4*i +: 4] = hv; m_dpm[i] = ~s[7]; end
      end
    end
    if (!ok) m_err = 1'b1;
    if (&m_seen) begin
      e.at_edge = at; e.val = m_val; e.dpm = m_dpm; e.err = m_err;
      exp_q.push_back(e);
      m_seen = '0; m_err = 1'b0;
    end
  endtask

  // Hold pins for len sampling edges; identical back-to-back pins extend one dwell.
  task automatic dwell(input logic [NDIG-1:0] a, input logic [7:0] s, input int len);
    logic [NDIG+7:0] p;
    p = {a, s};
    an = a; seg = s;
    if (!r_fresh && p == r_pins) begin
      r_len += len;
    end else begin
      r_pins = p; r_start = cyc + 1; r_len = len; r_acc = 1'b0; r_fresh = 1'b0;
    end
    if ($countones(~a) == 1 && !r_acc && r_len >= S) begin
      r_acc = 1'b1;
      m_accept(a, s, r_start + S);
    end
    repeat (len) begin @(posedge clk); #1; end
  endtask

  task automatic dig(input int i, input logic [3:0] h, input bit d, input int len);
    logic [NDIG-1:0] a;
    a = ~(NDIG'(1) << i);
    dwell(a, {~d, tab[h]}, len);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    m_clear();
    repeat (n) begin
      an = NDIG'($urandom); seg = 8'($urandom);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
  endtask

  logic [4*NDIG-1:0] exp_val = '0;
  logic [NDIG-1:0]   exp_dp  = '0;
  logic              exp_err = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_val = '0; exp_dp = '0; exp_err = 1'b0;
      check("rst_fv", 32'(frame_valid), 32'd0);
    end else if (exp_q.size() > 0 && exp_q[0].at_edge == cyc) begin
      ev_t e;
      e = exp_q.pop_front();
      exp_val = e.val; exp_dp = e.dpm; exp_err = e.err;
      check("frame_valid_hi", 32'(frame_valid), 32'd1);
    end else begin
      check("frame_valid_lo", 32'(frame_valid), 32'd0);
    end
    check("value", 32'(value), 32'(exp_val));
    check("dp", 32'(dp), 32'(exp_dp));
    check("frame_err", 32'(frame_err), 32'(exp_err));
  end

  initial begin
    logic [NDIG-1:0] a;
    logic [7:0]      s;
    logic [3:0]      h;
    an = '1; seg = '1; rst_n = 1'b0;
    m_clear();

    // Reset with arbitrary pins, then an idle display.
    do_reset(5);
    dwell('1, 8'hFF, 10);

    // Nominal frame 4321.
    for (int i = 0; i < NDIG; i++) dig(i, 4'(i + 1), 1'b0, 8);
    dwell('1, 8'hFF, 4);

    // Full code table with random dp.
    for (int f = 0; f < 16; f++)
      for (int i = 0; i < NDIG; i++)
        dig(i, 4'((f + i) & 15), 1'($urandom), S + $urandom_range(0, 4));

    // Short dwell on digit 2 followed by a multi-select glitch.
    dig(0, 4'h7, 1'b0, S + 1);
    dig(1, 4'h6, 1'b1, S + 1);
    dig(3, 4'h5, 1'b0, S + 1);
    dig(2, 4'hA, 1'b0, S - 1);
    dwell(4'b0011, {1'b1, tab[4'hA]}, 5);
    dwell('1, 8'hFF, 3);
    dig(2, 4'hA, 1'b0, S + 2);

    // Invalid pattern on digit 1 after a clean frame of 5s, then a clean frame.
    for (int i = 0; i < NDIG; i++) dig(i, 4'h5, 1'b0, S + 1);
    dig(0, 4'h9, 1'b0, S + 1);
    dwell(~(NDIG'(1) << 1), 8'hFF, S + 1);
    dig(2, 4'h9, 1'b0, S + 1);
    dig(3, 4'h9, 1'b0, S + 1);
    for (int i = 0; i < NDIG; i++) dig(i, 4'h9, 1'b0, S + 1);

    // Reset mid-frame.
    dig(0, 4'h1, 1'b1, S + 2);
    dig(1, 4'h2, 1'b1, S + 2);
    do_reset(3);
    dig(2, 4'hC, 1'b0, S + 1);
    dig(3, 4'hD, 1'b1, S + 1);
    dig(0, 4'hE, 1'b0, S + 1);
    dig(1, 4'hF, 1'b1, S + 1);

    // Random dwells: invalid patterns, multi-select, short dwells, re-accepts.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 9) < 7) a = ~(NDIG'(1) << $urandom_range(0, NDIG - 1));
      else                          a = NDIG'($urandom);
      h = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) < 8) s = {1'($urandom), tab[h]};
      else                          s = 8'($urandom);
      dwell(a, s, $urandom_range(1, S + 3));
    end

    dwell('1, 8'hFF, S + 4);
    check("pending_frames", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
